i2c_wb_arbiter: RTL and testbench
=================================

Name: i2c_wb_arbiter

Overview:
Two-requester Wishbone B4 classic arbiter that shares the single Wishbone slave port of the I2C master core. Typical requesters are the management SoC bus and an on-chip autonomous I2C polling engine.
- Grants the bus per-cycle (CYC-framed), round-robin on contention.
- Muxes the winning requester's signals to the slave and routes responses back.
- Optionally aborts hung transfers with a bus error.

Parameters:
AW, 32, address width of all adr ports
DW, 32, data width; sel width is DW/8
TIMEOUT_CYCLES, 256, cycles of STB without ACK before a timeout error (used only with the optional feature; must be >= 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  requester 0 cycle, strobe and write-enable
m0_sel_i  in  DW/8  requester 0 byte selects
m0_adr_i  in  AW  requester 0 address
m0_dat_i  in  DW  requester 0 write data
m0_dat_o  out  DW  requester 0 read data
m0_ack_o  out  1  requester 0 acknowledge
m0_err_o  out  1  requester 0 timeout error
m1_*  (same set as m0_*)  requester 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to I2C core
s_sel_o  out  DW/8  to I2C core
s_adr_o  out  AW  to I2C core
s_dat_o  out  DW  write data to I2C core
s_dat_i  in  DW  read data from I2C core
s_ack_i  in  1  acknowledge from I2C core
grant_o  out  2  one-hot current owner (status/debug)

Behaviour:
- The clock port is clk_i and the reset port is rst_i; there is one clock, and reset is asynchronous and active-high.
- Reset state:
  - state=IDLE, grant_o=2'b00, last_owner=1 (so m0 wins the first tie), timeout counter=0.
  - All s_* outputs, m*_ack_o, m*_err_o and m*_dat_o are 0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_cyc_i high -> OWN0 next edge.
  - Only m1_cyc_i high -> OWN1.
  - Both high -> grant the requester that is not last_owner.
  - Neither high -> stay IDLE.
- OWNx:
  - Stay while mx_cyc_i=1.
  - When mx_cyc_i=0, go to IDLE next edge and set last_owner=x.
  - There is no direct OWN0<->OWN1 handoff: a release always passes through one IDLE cycle.
- Latency:
  - Request seen in IDLE at edge N -> s_cyc_o first high in cycle N+1.
  - Owner drops CYC in cycle N -> the other requester is granted in cycle N+2.
- Datapath (combinational from the registered grant):
  - s_{cyc,stb,we,sel,adr,dat}_o = owner's inputs; all zero when IDLE.
  - Owner: mx_dat_o=s_dat_i and mx_ack_o=s_ack_i.
  - Non-owner: dat_o=0, ack_o=0, err_o=0.
- Responses outside a grant: s_ack_i while IDLE is ignored and not forwarded.
- Owner abort: CYC dropped mid-transfer without ACK still releases the grant. A late s_ack_i arriving after the release is dropped.
- Held CYC: a non-owner that holds CYC waits indefinitely; there is no preemption.
- Bursts: the owner may issue back-to-back STB cycles while holding CYC; the grant persists.
- Reset asserted mid-transfer: everything returns asynchronously to the reset state, and s_cyc_o drops immediately.

Optional Feature:
Macro: WB_ARB_TIMEOUT_EN
- Defined:
  - A counter increments each cycle that s_cyc_o&s_stb_o&~s_ack_i holds.
  - The counter clears on s_ack_i, on a grant change, or on STB low.
  - When the count equals TIMEOUT_CYCLES-1, for that single cycle: owner mx_err_o=1, mx_ack_o=0, and s_stb_o is forced 0. The counter then clears.
  - The grant is kept; the owner is expected to drop CYC or retry.
- Undefined: m0_err_o=m1_err_o=0 constantly; no counter logic is synthesized.

Test Plan:
- Reset release, then m0 single read at adr 0x0000_0004 with s_ack_i one cycle later and s_dat_i=0xA5A5_0001 -> s_cyc_o high in cycle 1 after the request, m0_dat_o=0xA5A5_0001 with m0_ack_o, and grant_o 01 -> 00 after m0_cyc_i drops.
- m0 and m1 raise CYC in the same cycle right after reset -> m0 granted first. After m0 releases, m1 is granted two cycles after m0 drops CYC. A second tie then goes to m0 (round-robin alternates).
- m1 owns and issues a 4-beat write burst (CYC held, data 0x11/0x22/0x33/0x44) while m0 requests -> all four beats reach s_dat_o in order, m0 sees no ack, and m0 is granted only after the burst ends.
- m0 drops CYC before ACK, then s_ack_i pulses while IDLE -> neither m0_ack_o nor m1_ack_o asserts, and grant_o=00.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m0 strobes with s_ack_i held 0 -> m0_err_o pulses in the 8th STB cycle with s_stb_o low that cycle, and m0_ack_o never asserts. Without the macro, m0_err_o stays 0.
- rst_i pulsed asynchronously mid-transfer while m1 owns -> s_cyc_o, grant_o and m1_ack_o go 0 without a clock edge, and the next tie after reset goes to m0.

Source files
------------

// File: rtl/i2c_wb_arbiter.sv
// Two-requester Wishbone B4 classic arbiter in front of the I2C master core slave port.
// Optional hung-transfer abort with bus error is enabled by defining WB_ARB_TIMEOUT_EN.
module i2c_wb_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   output logic [1:0]      grant_o
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

   state_e state_q, state_d;
   logic   lastOwner_q, lastOwner_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lastOwner_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         lastOwner_q <= lastOwner_d;
      end
   end

   // A release always returns to IDLE first, so a tie is decided only there.
   always_comb begin
      state_d     = state_q;
      lastOwner_d = lastOwner_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_d = lastOwner_q ? OWN0 : OWN1;
            else if (m0_cyc_i)        state_d = OWN0;
            else if (m1_cyc_i)        state_d = OWN1;
         end
         OWN0: begin
            if (!m0_cyc_i) begin
               state_d     = IDLE;
               lastOwner_d = 1'b0;
            end
         end
         OWN1: begin
            if (!m1_cyc_i) begin
               state_d     = IDLE;
               lastOwner_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_o = {state_q == OWN1, state_q == OWN0};

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] toCnt_q, toCnt_d;
   logic          ownerStb;
   logic          timeoutHit;

   assign ownerStb   = ((state_q == OWN0) && m0_cyc_i && m0_stb_i) ||
                       ((state_q == OWN1) && m1_cyc_i && m1_stb_i);
   assign timeoutHit = ownerStb && (toCnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Counts consecutive unacknowledged strobe cycles of the current owner.
   always_comb begin
      toCnt_d = toCnt_q + CW'(1);
      if (timeoutHit || s_ack_i || !ownerStb || (state_d != state_q)) toCnt_d = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) toCnt_q <= '0;
      else       toCnt_q <= toCnt_d;
   end
`endif

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (state_q)
         OWN0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
         end
         OWN1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
         end
         default: ;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      // The aborted strobe is withdrawn from the core while the owner sees the error.
      if (timeoutHit) begin
         s_stb_o  = 1'b0;
         m0_ack_o = 1'b0;
         m1_ack_o = 1'b0;
         m0_err_o = (state_q == OWN0);
         m1_err_o = (state_q == OWN1);
      end
`endif
   end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Directed self-checking bench for i2c_wb_arbiter (TIMEOUT_CYCLES=8; honours WB_ARB_TIMEOUT_EN).
module tb_i2c_wb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk_i, rst_i;
   logic            m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
   logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
   logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i;
   logic [1:0]      grant_o;

   int total = 0;
   int bad   = 0;

   i2c_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic cyc, input logic stb,
                                input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat);
      if (idx == 0) begin
         m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
         m0_sel_i = cyc ? 4'hF : 4'h0; m0_adr_i = adr; m0_dat_i = dat;
      end else begin
         m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
         m1_sel_i = cyc ? 4'hF : 4'h0; m1_adr_i = adr; m1_dat_i = dat;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Pulse reset between clock edges.
   task automatic pulseReset();
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
   endtask

   logic [DW-1:0] burstData [4];

   initial begin
      burstData[0] = 32'h11; burstData[1] = 32'h22;
      burstData[2] = 32'h33; burstData[3] = 32'h44;
      rst_i = 1'b1;
      s_ack_i = 1'b0;
      s_dat_i = '0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      #2;
      checkOutput("rst_grant", grant_o, 2'b00);
      checkOutput("rst_scyc", s_cyc_o, 0);
      checkOutput("rst_sstb", s_stb_o, 0);
      checkOutput("rst_m0ack", m0_ack_o, 0);
      checkOutput("rst_m1ack", m1_ack_o, 0);
      checkOutput("rst_m0dat", m0_dat_o, 0);
      checkOutput("rst_sdat", s_dat_o, 0);
      tick();
      tick();
      rst_i = 1'b0;

      // Single m0 read
      applyStimulus(0, 1, 1, 0, 32'h0000_0004, 0);
      settle();
      checkOutput("t1_idle_scyc", s_cyc_o, 0);
      tick();
      checkOutput("t1_scyc", s_cyc_o, 1);
      checkOutput("t1_sadr", s_adr_o, 32'h0000_0004);
      checkOutput("t1_grant", grant_o, 2'b01);
      checkOutput("t1_noack", m0_ack_o, 0);
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'hA5A5_0001;
      settle();
      checkOutput("t1_m0ack", m0_ack_o, 1);
      checkOutput("t1_m0dat", m0_dat_o, 32'hA5A5_0001);
      checkOutput("t1_m1ack", m1_ack_o, 0);
      checkOutput("t1_m1dat", m1_dat_o, 0);
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t1_rel_grant", grant_o, 2'b01);
      tick();
      checkOutput("t1_idle_grant", grant_o, 2'b00);

      // Tie right after reset, then round-robin
      pulseReset();
      applyStimulus(0, 1, 1, 0, 32'h100, 0);
      applyStimulus(1, 1, 1, 0, 32'h200, 0);
      tick();
      checkOutput("t2_tie1_grant", grant_o, 2'b01);
      checkOutput("t2_tie1_adr", s_adr_o, 32'h100);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t2_n1_grant", grant_o, 2'b00);
      tick();
      checkOutput("t2_n2_grant", grant_o, 2'b10);
      checkOutput("t2_n2_adr", s_adr_o, 32'h200);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t2_idle", grant_o, 2'b00);
      applyStimulus(0, 1, 1, 0, 32'h100, 0);
      applyStimulus(1, 1, 0, 0, 32'h300, 0);
      tick();
      checkOutput("t2_tie2_grant", grant_o, 2'b01);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("t3_m1_owns", grant_o, 2'b10);

      // m1 write burst while m0 waits
      applyStimulus(0, 1, 1, 0, 32'h0000_0040, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 1, 1, 32'h10 + i, burstData[i]);
         s_ack_i = 1'b1;
         settle();
         checkOutput($sformatf("t3_sdat%0d", i), s_dat_o, burstData[i]);
         checkOutput($sformatf("t3_swe%0d", i), s_we_o, 1);
         checkOutput($sformatf("t3_m1ack%0d", i), m1_ack_o, 1);
         checkOutput($sformatf("t3_m0ack%0d", i), m0_ack_o, 0);
         checkOutput($sformatf("t3_grant%0d", i), grant_o, 2'b10);
         tick();
      end
      s_ack_i = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t3_idle", grant_o, 2'b00);
      tick();
      checkOutput("t3_m0_grant", grant_o, 2'b01);
      checkOutput("t3_m0_adr", s_adr_o, 32'h0000_0040);

      // m0 aborts, late ack while IDLE is dropped
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'hDEAD_BEEF;
      settle();
      checkOutput("t4_m0ack", m0_ack_o, 0);
      checkOutput("t4_m1ack", m1_ack_o, 0);
      checkOutput("t4_m0dat", m0_dat_o, 0);
      checkOutput("t4_grant", grant_o, 2'b00);
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;

      // Hung strobe: error in the 8th STB cycle when the timeout is built in
      applyStimulus(0, 1, 1, 0, 32'h8, 0);
      tick();
      for (int k = 1; k <= 9; k++) begin
         settle();
`ifdef WB_ARB_TIMEOUT_EN
         checkOutput($sformatf("t5_err%0d", k), m0_err_o, (k == 8));
         checkOutput($sformatf("t5_sstb%0d", k), s_stb_o, (k != 8));
`else
         checkOutput($sformatf("t5_err%0d", k), m0_err_o, 0);
         checkOutput($sformatf("t5_sstb%0d", k), s_stb_o, 1);
`endif
         checkOutput($sformatf("t5_ack%0d", k), m0_ack_o, 0);
         checkOutput($sformatf("t5_grant%0d", k), grant_o, 2'b01);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();

      // Async reset while m1 owns
      applyStimulus(0, 1, 1, 0, 32'h500, 0);
      applyStimulus(1, 1, 1, 0, 32'h600, 0);
      tick();
      checkOutput("t6_m1_grant", grant_o, 2'b10);
      s_ack_i = 1'b1;
      settle();
      checkOutput("t6_m1ack", m1_ack_o, 1);
      rst_i = 1'b1;
      #1;
      checkOutput("t6_rst_scyc", s_cyc_o, 0);
      checkOutput("t6_rst_grant", grant_o, 2'b00);
      checkOutput("t6_rst_m1ack", m1_ack_o, 0);
      rst_i = 1'b0;
      s_ack_i = 1'b0;
      tick();
      checkOutput("t6_tie_grant", grant_o, 2'b01);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
